// File: rtl/gelato_wb_pkg.sv
// Shared writeback types and source indices for the Gelato writeback arbiter.
package gelato_wb_pkg;

  localparam int unsigned WARP_W  = 5;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned THREADS = 32;
  localparam int unsigned DATA_W  = 32 * THREADS;

  localparam int unsigned NUM_WB_SRC     = 3;
  localparam int unsigned WB_SRC_COMPUTE = 0;
  localparam int unsigned WB_SRC_LSU     = 1;
  localparam int unsigned WB_SRC_TENSOR  = 2;

  typedef struct packed {
    logic [WARP_W-1:0]  warp;
    logic [REG_W-1:0]   rd;
    logic [THREADS-1:0] mask;
    logic [DATA_W-1:0]  data;
    logic               last;
  } wb_beat_t;

endpackage

// File: rtl/gelato_rr_picker.sv
// Combinational rotate-priority encoder: first request after ptr, wrapping modulo N.
module gelato_rr_picker #(
  parameter int unsigned N     = 3,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

  always_comb begin
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] idx;
    grant_valid = 1'b0;
    grant_idx   = '0;
    sum         = '0;
    idx         = '0;
    // ptr < N and k <= N, so one conditional subtract is a full modulo
    for (int k = 1; k <= int'(N); k++) begin
      sum = {1'b0, ptr} + (IDX_W + 1)'(k);
      if (sum >= (IDX_W + 1)'(N)) sum = sum - (IDX_W + 1)'(N);
      idx = sum[IDX_W-1:0];
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/gelato_wb_arbiter.sv
// Round-robin writeback arbiter with locked bursts and a single registered output beat.
module gelato_wb_arbiter
  import gelato_wb_pkg::*;
#(
  parameter int unsigned NUM_SRC = NUM_WB_SRC,
  parameter int unsigned SRC_W   = $clog2(NUM_SRC)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rdy,
  input  logic [NUM_SRC-1:0]            src_valid,
  output logic [NUM_SRC-1:0]            src_ready,
  input  wb_beat_t [NUM_SRC-1:0]        src_beat,
  output logic                          wb_valid,
  input  logic                          wb_ready,
  output wb_beat_t                      wb_beat,
  output logic [SRC_W-1:0]              wb_src,
  output logic                          busy
);

  logic             out_valid_q, out_valid_d;
  wb_beat_t         out_beat_q, out_beat_d;
  logic [SRC_W-1:0] out_src_q, out_src_d;
  logic [SRC_W-1:0] ptr_q, ptr_d;
  logic             locked_q, locked_d;
  logic [SRC_W-1:0] lock_src_q, lock_src_d;

  logic [NUM_SRC-1:0] req;
  logic [SRC_W-1:0]   grant_idx;
  logic               grant_valid;
  logic               slot_free;
  logic               accept;

  // While locked only the burst owner may be granted; its idle cycles become bubbles
  always_comb begin
    req = src_valid;
    if (locked_q) req = src_valid & (NUM_SRC'(1) << lock_src_q);
  end

  gelato_rr_picker #(
    .N     (NUM_SRC),
    .IDX_W (SRC_W)
  ) u_picker (
    .req         (req),
    .ptr         (ptr_q),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign slot_free = !out_valid_q || wb_ready;
  assign accept    = rdy && slot_free && grant_valid;

  always_comb begin
    src_ready = '0;
    if (accept) src_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_beat_d  = out_beat_q;
    out_src_d   = out_src_q;
    ptr_d       = ptr_q;
    locked_d    = locked_q;
    lock_src_d  = lock_src_q;
    if (rdy) begin
      if (accept) begin
        out_valid_d = 1'b1;
        out_beat_d  = src_beat[grant_idx];
        out_src_d   = grant_idx;
        ptr_d       = grant_idx;
        locked_d    = !src_beat[grant_idx].last;
        lock_src_d  = grant_idx;
      end else if (slot_free) begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_beat_q  <= '0;
      out_src_q   <= '0;
      ptr_q       <= SRC_W'(NUM_SRC - 1);
      locked_q    <= 1'b0;
      lock_src_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_beat_q  <= out_beat_d;
      out_src_q   <= out_src_d;
      ptr_q       <= ptr_d;
      locked_q    <= locked_d;
      lock_src_q  <= lock_src_d;
    end
  end

  assign wb_valid = out_valid_q;
  assign wb_beat  = out_beat_q;
  assign wb_src   = out_src_q;
  assign busy     = out_valid_q || locked_q;

endmodule

// File: tb/tb_gelato_wb_arbiter.sv
// Scoreboard bench for gelato_wb_arbiter: directed beats, expected order queued, monitor compares.
module tb_gelato_wb_arbiter;
  import gelato_wb_pkg::*;

  typedef struct {
    logic [1:0] src;
    wb_beat_t   beat;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             rdy;
  logic [2:0]       src_valid;
  logic [2:0]       src_ready;
  wb_beat_t [2:0]   src_beat;
  logic             wb_valid;
  logic             wb_ready;
  wb_beat_t         wb_beat;
  logic [1:0]       wb_src;
  logic             busy;

  int n_tests = 0;
  int n_fail  = 0;

  exp_t     exp_q[$];
  wb_beat_t sq[3][$];

  gelato_wb_arbiter #(
    .NUM_SRC (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rdy       (rdy),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .src_beat  (src_beat),
    .wb_valid  (wb_valid),
    .wb_ready  (wb_ready),
    .wb_beat   (wb_beat),
    .wb_src    (wb_src),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic wb_beat_t mk(input int src, input int n, input bit last);
    wb_beat_t b;
    b = '0;
    b.warp = 5'(n + src);
    b.rd   = 5'(src + 1);
    b.mask = (src == 2 && n == 1) ? '0 : (32'hFFFF_0000 | 32'(n));
    b.data[31:0] = 32'(src * 256 + n);
    b.data[DATA_W-1 -: 32] = ~b.data[31:0];
    b.last = last;
    return b;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic chk_beat(input string name, input wb_beat_t act, input wb_beat_t req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got warp %0d rd %0d mask %h data %h last %b, required warp %0d rd %0d mask %h data %h last %b",
               name, act.warp, act.rd, act.mask, act.data[31:0], act.last,
               req.warp, req.rd, req.mask, req.data[31:0], req.last);
    end
  endtask

  task automatic src_push(input int src, input int n, input bit last);
    sq[src].push_back(mk(src, n, last));
  endtask

  task automatic expect_beat(input int src, input int n, input bit last);
    exp_t e;
    e.src  = 2'(src);
    e.beat = mk(src, n, last);
    exp_q.push_back(e);
  endtask

  task automatic drive();
    for (int i = 0; i < 3; i++) begin
      src_valid[i] = (sq[i].size() != 0);
      src_beat[i]  = src_valid[i] ? sq[i][0] : '0;
    end
  endtask

  // Sample accepts before the edge, retire them after it, then present the next heads
  task automatic tick();
    logic [2:0] acc;
    @(negedge clk);
    acc = src_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      if (acc[i] && sq[i].size() != 0) void'(sq[i].pop_front());
    end
    drive();
    #1;
  endtask

  task automatic drain(input string name);
    int c;
    c = 0;
    while ((exp_q.size() != 0 || sq[0].size() != 0 || sq[1].size() != 0 ||
            sq[2].size() != 0) && c < 60) begin
      tick();
      c++;
    end
    n_tests++;
    if (c >= 60) begin
      n_fail++;
      $display("FAIL %s drain: got %0d beats still pending, required 0", name, exp_q.size());
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && rdy && wb_valid && wb_ready) begin
      exp_t e;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL monitor: got unexpected beat src %0d data %h, required none",
                 wb_src, wb_beat.data[31:0]);
      end else begin
        e = exp_q.pop_front();
        chk("monitor wb_src", 64'(wb_src), 64'(e.src));
        chk_beat("monitor wb_beat", wb_beat, e.beat);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    rdy       = 1'b1;
    wb_ready  = 1'b1;
    src_valid = '0;
    src_beat  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset wb_valid", 64'(wb_valid), 64'd0);
    chk("reset src_ready", 64'(src_ready), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset wb_src", 64'(wb_src), 64'd0);
    chk_beat("reset wb_beat", wb_beat, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;

    // All three valid, single beats: 0,1,2,0,1,2
    for (int n = 0; n < 2; n++) begin
      for (int s = 0; s < 3; s++) begin
        src_push(s, n, 1'b1);
        expect_beat(s, n, 1'b1);
      end
    end
    drive();
    #1;
    chk("rr first grant", 64'(src_ready), 64'b001);
    chk("rr latency wb_valid early", 64'(wb_valid), 64'd0);
    tick();
    chk("rr latency wb_valid", 64'(wb_valid), 64'd1);
    chk("rr latency wb_src", 64'(wb_src), 64'd0);
    chk("rr second grant", 64'(src_ready), 64'b010);
    drain("rr");

    // ptr=2, only source 1 valid; then ptr=1 with sources 0 and 2
    src_push(1, 2, 1'b1);
    expect_beat(1, 2, 1'b1);
    drive();
    #1;
    chk("lone src1 grant", 64'(src_ready), 64'b010);
    drain("lone src1");
    src_push(0, 3, 1'b1);
    src_push(2, 3, 1'b1);
    expect_beat(2, 3, 1'b1);
    expect_beat(0, 3, 1'b1);
    drive();
    #1;
    chk("ptr1 grant", 64'(src_ready), 64'b100);
    drain("ptr1");

    // ptr=0: lsu single, then tensor 4-beat burst locks out compute
    src_push(0, 4, 1'b1);
    src_push(0, 5, 1'b1);
    src_push(1, 4, 1'b1);
    for (int n = 4; n < 8; n++) src_push(2, n, n == 7);
    expect_beat(1, 4, 1'b1);
    for (int n = 4; n < 8; n++) expect_beat(2, n, n == 7);
    expect_beat(0, 4, 1'b1);
    expect_beat(0, 5, 1'b1);
    drive();
    #1;
    chk("burst pre grant", 64'(src_ready), 64'b010);
    tick();
    chk("burst start grant", 64'(src_ready), 64'b100);
    tick();
    chk("burst locked grant", 64'(src_ready), 64'b100);
    chk("burst busy", 64'(busy), 64'd1);
    drain("burst");

    // Output stall: beat must hold, no accepts
    src_push(1, 8, 1'b1);
    src_push(1, 9, 1'b1);
    src_push(0, 8, 1'b1);
    expect_beat(1, 8, 1'b1);
    expect_beat(0, 8, 1'b1);
    expect_beat(1, 9, 1'b1);
    drive();
    tick();
    wb_ready = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("stall src_ready", 64'(src_ready), 64'd0);
      chk("stall busy", 64'(busy), 64'd1);
      chk("stall wb_valid", 64'(wb_valid), 64'd1);
      chk("stall wb_src", 64'(wb_src), 64'd1);
      chk_beat("stall wb_beat", wb_beat, mk(1, 8, 1'b1));
      tick();
    end
    wb_ready = 1'b1;
    drain("stall");

    // Global enable low: everything frozen
    for (int s = 0; s < 3; s++) src_push(s, 10, 1'b1);
    expect_beat(2, 10, 1'b1);
    expect_beat(0, 10, 1'b1);
    expect_beat(1, 10, 1'b1);
    drive();
    tick();
    rdy = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rdy0 src_ready", 64'(src_ready), 64'd0);
      chk("rdy0 wb_valid", 64'(wb_valid), 64'd1);
      chk("rdy0 wb_src", 64'(wb_src), 64'd2);
      chk_beat("rdy0 wb_beat", wb_beat, mk(2, 10, 1'b1));
      tick();
    end
    rdy = 1'b1;
    drain("rdy0");

    // Reset in the middle of a source-1 burst
    wb_ready = 1'b0;
    for (int n = 11; n < 15; n++) src_push(1, n, n == 14);
    drive();
    #1;
    chk("rst burst grant", 64'(src_ready), 64'b010);
    tick();
    src_push(0, 11, 1'b1);
    drive();
    #1;
    chk("rst burst stalled", 64'(src_ready), 64'd0);
    chk("rst burst busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    for (int s = 0; s < 3; s++) sq[s].delete();
    exp_q.delete();
    drive();
    #1;
    chk("midrst wb_valid", 64'(wb_valid), 64'd0);
    chk("midrst busy", 64'(busy), 64'd0);
    chk("midrst src_ready", 64'(src_ready), 64'd0);
    chk_beat("midrst wb_beat", wb_beat, '0);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    wb_ready = 1'b1;
    src_push(1, 15, 1'b1);
    src_push(0, 15, 1'b1);
    expect_beat(0, 15, 1'b1);
    expect_beat(1, 15, 1'b1);
    drive();
    #1;
    chk("post rst grant", 64'(src_ready), 64'b001);
    drain("post rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
